back_ground_draw_frame: RTL and testbench
=========================================

// Module: back_ground_draw_frame
// PURPOSE
//  Parametrised background/border generator for the VGA path. Per pixel it outputs an 8-bit
//  RRRGGGBB colour and a bracket-collision request, with configurable frame size, bracket
//  offset/thickness and colours. Adds a frame-synchronous bracket flash effect (FSM-driven)
//  triggered by game logic. Feeds the lowest-priority layer of the object mux.
// PARAMETERS
//  X_FRAME_SIZE   639          last visible column
//  Y_FRAME_SIZE   479          last visible row
//  BRACKET_OFFSET 30           distance of inner bracket from frame edge, pixels
//  BRACKET_WIDTH  1            bracket thickness, pixels (>=1)
//  FLASH_FRAMES   8            frames per flash half-period (>=1)
//  FLASH_COUNT    3            on/off flash cycles per request (>=1)
//  BG_COLOR       8'b010_110_00 fill colour
//  EDGE_COLOR     8'b111_111_00 outer 1-pixel frame colour
//  BRACKET_COLOR  8'b100_000_00 bracket colour, steady
//  FLASH_COLOR    8'b111_111_11 bracket colour while flashing on
// PORTS
//  clk             in  1   pixel clock
//  reset           in  1   asynchronous, active-high reset
//  pixelX          in  11  current pixel column
//  pixelY          in  11  current pixel row
//  startOfFrame    in  1   one-cycle strobe, first cycle of each frame
//  flashReq        in  1   one-cycle request to start a flash sequence
//  BG_RGB          out 8   registered pixel colour
//  boardersDrawReq out 1   registered; 1 on bracket pixels
//  flashBusy       out 1   registered; 1 while a flash sequence is pending/active
// BEHAVIOUR
//  - Reset (async, active-high): BG_RGB=8'h00, boardersDrawReq=0, flashBusy=0, state=STEADY,
//    frameCnt=0, cycleCnt=0. Reset asserted mid-flash aborts the flash immediately.
//  - Latency: BG_RGB/boardersDrawReq reflect pixelX/pixelY of the previous clk (1 cycle).
//  - Decode (unsigned 11-bit compares):
//    outside = pixelX>X_FRAME_SIZE || pixelY>Y_FRAME_SIZE
//    edge    = pixelX==0 || pixelY==0 || pixelX==X_FRAME_SIZE || pixelY==Y_FRAME_SIZE
//    bracket = pixelX in [BRACKET_OFFSET, BRACKET_OFFSET+BRACKET_WIDTH-1]
//           or pixelX in [X_FRAME_SIZE-BRACKET_OFFSET-BRACKET_WIDTH+1, X_FRAME_SIZE-BRACKET_OFFSET]
//           or same two ranges for pixelY against Y_FRAME_SIZE
//  - Priority: outside -> 8'h00, req 0; bracket -> bracket colour, req 1; edge -> EDGE_COLOR;
//    else BG_COLOR. boardersDrawReq is 1 on bracket pixels in every FSM state.
//  - Bracket colour = FLASH_COLOR in FLASH_ON, else BRACKET_COLOR.
//  - FSM (state changes only on startOfFrame, except arming; no mid-frame tearing):
//    STEADY:    flashReq & startOfFrame -> FLASH_ON; flashReq alone -> ARMED.
//    ARMED:     startOfFrame -> FLASH_ON (frameCnt=0, cycleCnt=0).
//    FLASH_ON:  on startOfFrame frameCnt++; at frameCnt==FLASH_FRAMES-1 -> FLASH_OFF, frameCnt=0.
//    FLASH_OFF: on startOfFrame frameCnt++; at frameCnt==FLASH_FRAMES-1: frameCnt=0;
//               cycleCnt==FLASH_COUNT-1 -> STEADY (cycleCnt=0), else cycleCnt++ -> FLASH_ON.
//  - flashReq while not STEADY is ignored (not queued, no retrigger).
//  - flashBusy=1 in ARMED/FLASH_ON/FLASH_OFF; registered, 1 cycle after state change.
//  - Counters sized $clog2(param)+1 bits; no wrap within legal params.
//  - Legal params: BRACKET_OFFSET+BRACKET_WIDTH <= Y_FRAME_SIZE/2; out-of-range is unsupported.
// TESTING
//  - Reset mid-frame: reset=1 -> BG_RGB=8'h00, boardersDrawReq=0, flashBusy=0 without clk edge.
//  - Defaults, raster (0,0),(30,100),(100,100),(609,5),(700,10) -> 8'hFC, 8'h80/req1, 8'h58,
//    8'h80/req1, 8'h00/req0, each one cycle after the pixel is applied.
//  - BRACKET_WIDTH=3: pixelX=30,32 -> bracket; 33 -> BG; pixelX=607 -> bracket; 606 -> BG.
//  - flashReq mid-frame, FLASH_FRAMES=2, FLASH_COUNT=2: ARMED, then ON 2 frames (brackets 8'hFF),
//    OFF 2, ON 2, OFF 2, STEADY; flashBusy high for exactly the span from arming to end.
//  - flashReq coincident with startOfFrame in STEADY -> FLASH_ON at that strobe; second
//    flashReq during FLASH_OFF ignored, sequence length unchanged.
//  - Reset asserted during FLASH_ON -> STEADY, brackets back to 8'h80 after release.

Source files
------------

// File: rtl/back_ground_draw_frame_if.sv
// Pixel-stream bundle between the raster timing generator and the background layer.
// Master drives coordinates and strobes; slave returns the registered pixel and status.
interface back_ground_draw_frame_if;
  logic [10:0] pixelX;
  logic [10:0] pixelY;
  logic        startOfFrame;
  logic        flashReq;
  logic [7:0]  BG_RGB;
  logic        boardersDrawReq;
  logic        flashBusy;

  modport master (
    output pixelX, pixelY, startOfFrame, flashReq,
    input  BG_RGB, boardersDrawReq, flashBusy
  );

  modport slave (
    input  pixelX, pixelY, startOfFrame, flashReq,
    output BG_RGB, boardersDrawReq, flashBusy
  );
endinterface

// File: rtl/back_ground_draw_frame.sv
// Background, edge and bracket pixel generator with a frame-synchronous bracket flash FSM.
// One-cycle registered latency from pixel coordinates; no backpressure (pixel-rate stream).
module back_ground_draw_frame #(
  parameter int         X_FRAME_SIZE   = 639,
  parameter int         Y_FRAME_SIZE   = 479,
  parameter int         BRACKET_OFFSET = 30,
  parameter int         BRACKET_WIDTH  = 1,
  parameter int         FLASH_FRAMES   = 8,
  parameter int         FLASH_COUNT    = 3,
  parameter logic [7:0] BG_COLOR       = 8'b010_110_00,
  parameter logic [7:0] EDGE_COLOR     = 8'b111_111_00,
  parameter logic [7:0] BRACKET_COLOR  = 8'b100_000_00,
  parameter logic [7:0] FLASH_COLOR    = 8'b111_111_11
) (
  input  logic                      clk,
  input  logic                      reset,
  back_ground_draw_frame_if.slave   bus
);

  localparam int FW = $clog2(FLASH_FRAMES) + 1;
  localparam int CW = $clog2(FLASH_COUNT) + 1;

  localparam logic [10:0] X_MAX = 11'(X_FRAME_SIZE);
  localparam logic [10:0] Y_MAX = 11'(Y_FRAME_SIZE);
  localparam logic [10:0] BX_L0 = 11'(BRACKET_OFFSET);
  localparam logic [10:0] BX_L1 = 11'(BRACKET_OFFSET + BRACKET_WIDTH - 1);
  localparam logic [10:0] BX_R0 = 11'(X_FRAME_SIZE - BRACKET_OFFSET - BRACKET_WIDTH + 1);
  localparam logic [10:0] BX_R1 = 11'(X_FRAME_SIZE - BRACKET_OFFSET);
  localparam logic [10:0] BY_R0 = 11'(Y_FRAME_SIZE - BRACKET_OFFSET - BRACKET_WIDTH + 1);
  localparam logic [10:0] BY_R1 = 11'(Y_FRAME_SIZE - BRACKET_OFFSET);

  localparam logic [FW-1:0] FRAME_LAST = FW'(FLASH_FRAMES - 1);
  localparam logic [CW-1:0] CYCLE_LAST = CW'(FLASH_COUNT - 1);

  typedef enum logic [1:0] {
    ST_STEADY,
    ST_ARMED,
    ST_FLASH_ON,
    ST_FLASH_OFF
  } state_t;

  state_t        r_state;
  logic [FW-1:0] r_frame_cnt;
  logic [CW-1:0] r_cycle_cnt;
  logic          r_flash_busy;
  logic [7:0]    r_bg_rgb;
  logic          r_draw_req;

  logic       w_outside;
  logic       w_edge;
  logic       w_bracket;
  logic [7:0] w_bracket_color;

  always_comb begin
    w_outside = (bus.pixelX > X_MAX) || (bus.pixelY > Y_MAX);
    w_edge    = (bus.pixelX == 11'd0) || (bus.pixelY == 11'd0) ||
                (bus.pixelX == X_MAX) || (bus.pixelY == Y_MAX);
    // Left/top ranges share the same offsets; right/bottom mirror from the far edge.
    w_bracket = ((bus.pixelX >= BX_L0) && (bus.pixelX <= BX_L1)) ||
                ((bus.pixelX >= BX_R0) && (bus.pixelX <= BX_R1)) ||
                ((bus.pixelY >= BX_L0) && (bus.pixelY <= BX_L1)) ||
                ((bus.pixelY >= BY_R0) && (bus.pixelY <= BY_R1));
    w_bracket_color = (r_state == ST_FLASH_ON) ? FLASH_COLOR : BRACKET_COLOR;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bg_rgb   <= 8'h00;
      r_draw_req <= 1'b0;
    end else if (w_outside) begin
      r_bg_rgb   <= 8'h00;
      r_draw_req <= 1'b0;
    end else if (w_bracket) begin
      r_bg_rgb   <= w_bracket_color;
      r_draw_req <= 1'b1;
    end else if (w_edge) begin
      r_bg_rgb   <= EDGE_COLOR;
      r_draw_req <= 1'b0;
    end else begin
      r_bg_rgb   <= BG_COLOR;
      r_draw_req <= 1'b0;
    end
  end

  // State only moves on the frame strobe so a flash never tears mid-frame; arming is the exception.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_STEADY;
      r_frame_cnt  <= '0;
      r_cycle_cnt  <= '0;
      r_flash_busy <= 1'b0;
    end else begin
      r_flash_busy <= (r_state != ST_STEADY);
      case (r_state)
        ST_STEADY: begin
          if (bus.flashReq) begin
            r_frame_cnt <= '0;
            r_cycle_cnt <= '0;
            r_state     <= bus.startOfFrame ? ST_FLASH_ON : ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (bus.startOfFrame) begin
            r_frame_cnt <= '0;
            r_cycle_cnt <= '0;
            r_state     <= ST_FLASH_ON;
          end
        end
        ST_FLASH_ON: begin
          if (bus.startOfFrame) begin
            if (r_frame_cnt == FRAME_LAST) begin
              r_frame_cnt <= '0;
              r_state     <= ST_FLASH_OFF;
            end else begin
              r_frame_cnt <= r_frame_cnt + FW'(1);
            end
          end
        end
        ST_FLASH_OFF: begin
          if (bus.startOfFrame) begin
            if (r_frame_cnt == FRAME_LAST) begin
              r_frame_cnt <= '0;
              if (r_cycle_cnt == CYCLE_LAST) begin
                r_cycle_cnt <= '0;
                r_state     <= ST_STEADY;
              end else begin
                r_cycle_cnt <= r_cycle_cnt + CW'(1);
                r_state     <= ST_FLASH_ON;
              end
            end else begin
              r_frame_cnt <= r_frame_cnt + FW'(1);
            end
          end
        end
        default: r_state <= ST_STEADY;
      endcase
    end
  end

  assign bus.BG_RGB          = r_bg_rgb;
  assign bus.boardersDrawReq = r_draw_req;
  assign bus.flashBusy       = r_flash_busy;

endmodule

// File: tb/tb_back_ground_draw_frame.sv
// Bench for back_ground_draw_frame: one instance with a short flash sequence, one with wide brackets.
// Expected pixels are queued when driven and checked one clock later.
module tb_back_ground_draw_frame;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  back_ground_draw_frame_if ifa ();
  back_ground_draw_frame_if ifb ();

  back_ground_draw_frame #(.FLASH_FRAMES(2), .FLASH_COUNT(2)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa)
  );
  back_ground_draw_frame #(.BRACKET_WIDTH(3)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb)
  );

  int checks = 0;
  int errors = 0;

  string      tag_q[$];
  logic [7:0] rgb_q[$];
  logic       req_q[$];
  logic       busy_q[$];
  bit         bchk_q[$];
  logic [7:0] brgb_q[$];
  logic       breq_q[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Drive one pixel to both instances, queue the expectation, check it one edge later.
  task automatic step(input string tag, input int x, input int y, input bit sof, input bit freq,
                      input logic [7:0] rgb, input logic req, input logic busy,
                      input bit bchk = 1'b0, input logic [7:0] brgb = 8'h00, input logic breq = 1'b0);
    string t;
    ifa.pixelX       = 11'(x);
    ifa.pixelY       = 11'(y);
    ifa.startOfFrame = sof;
    ifa.flashReq     = freq;
    ifb.pixelX       = 11'(x);
    ifb.pixelY       = 11'(y);
    tag_q.push_back(tag);
    rgb_q.push_back(rgb);
    req_q.push_back(req);
    busy_q.push_back(busy);
    bchk_q.push_back(bchk);
    brgb_q.push_back(brgb);
    breq_q.push_back(breq);
    @(posedge clk);
    #1;
    ifa.startOfFrame = 1'b0;
    ifa.flashReq     = 1'b0;
    t = tag_q.pop_front();
    chk({t, "_rgb"},  32'(ifa.BG_RGB),          32'(rgb_q.pop_front()));
    chk({t, "_req"},  32'(ifa.boardersDrawReq), 32'(req_q.pop_front()));
    chk({t, "_busy"}, 32'(ifa.flashBusy),       32'(busy_q.pop_front()));
    if (bchk_q.pop_front()) begin
      chk({t, "_b_rgb"}, 32'(ifb.BG_RGB),          32'(brgb_q.pop_front()));
      chk({t, "_b_req"}, 32'(ifb.boardersDrawReq), 32'(breq_q.pop_front()));
    end else begin
      void'(brgb_q.pop_front());
      void'(breq_q.pop_front());
    end
  endtask

  task automatic sof_step(input logic busy, input bit freq = 1'b0);
    step("sof", 0, 0, 1'b1, freq, 8'hFC, 1'b0, busy);
  endtask

  task automatic body(input logic on, input logic busy, input bit freq = 1'b0);
    step("brk", 30, 100, 1'b0, freq, on ? 8'hFF : 8'h80, 1'b1, busy);
    step("bg", 100, 100, 1'b0, 1'b0, 8'h58, 1'b0, busy);
  endtask

  task automatic async_reset_check(input string tag);
    reset = 1'b1;
    #2;
    chk({tag, "_rgb"},  32'(ifa.BG_RGB),          32'h00);
    chk({tag, "_req"},  32'(ifa.boardersDrawReq), 32'h0);
    chk({tag, "_busy"}, 32'(ifa.flashBusy),       32'h0);
    chk({tag, "_b_rgb"}, 32'(ifb.BG_RGB),         32'h00);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset            = 1'b1;
    ifa.pixelX       = '0;
    ifa.pixelY       = '0;
    ifa.startOfFrame = 1'b0;
    ifa.flashReq     = 1'b0;
    ifb.pixelX       = '0;
    ifb.pixelY       = '0;
    ifb.startOfFrame = 1'b0;
    ifb.flashReq     = 1'b0;
    #2;
    chk("rst_rgb",  32'(ifa.BG_RGB),          32'h00);
    chk("rst_req",  32'(ifa.boardersDrawReq), 32'h0);
    chk("rst_busy", 32'(ifa.flashBusy),       32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Default raster decode
    step("r0_0",    0,   0, 1'b0, 1'b0, 8'hFC, 1'b0, 1'b0);
    step("r30_100", 30,  100, 1'b0, 1'b0, 8'h80, 1'b1, 1'b0);
    step("r100",    100, 100, 1'b0, 1'b0, 8'h58, 1'b0, 1'b0);
    step("r609_5",  609, 5,   1'b0, 1'b0, 8'h80, 1'b1, 1'b0);
    step("r700_10", 700, 10,  1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    step("r639_0",  639, 0,   1'b0, 1'b0, 8'hFC, 1'b0, 1'b0);
    step("r5_449",  5,   449, 1'b0, 1'b0, 8'h80, 1'b1, 1'b0);
    step("r5_480",  5,   480, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

    // Wide brackets on dut_b, narrow on dut_a
    step("w30",  30,  100, 1'b0, 1'b0, 8'h80, 1'b1, 1'b0, 1'b1, 8'h80, 1'b1);
    step("w32",  32,  100, 1'b0, 1'b0, 8'h58, 1'b0, 1'b0, 1'b1, 8'h80, 1'b1);
    step("w33",  33,  100, 1'b0, 1'b0, 8'h58, 1'b0, 1'b0, 1'b1, 8'h58, 1'b0);
    step("w607", 607, 100, 1'b0, 1'b0, 8'h58, 1'b0, 1'b0, 1'b1, 8'h80, 1'b1);
    step("w606", 606, 100, 1'b0, 1'b0, 8'h58, 1'b0, 1'b0, 1'b1, 8'h58, 1'b0);

    async_reset_check("rst_mid");

    // Flash requested mid-frame: arm, then ON,ON,OFF,OFF,ON,ON,OFF,OFF, back to steady
    sof_step(1'b0);
    body(1'b0, 1'b0);
    step("arm",  100, 100, 1'b0, 1'b1, 8'h58, 1'b0, 1'b0);
    step("armd", 30,  100, 1'b0, 1'b0, 8'h80, 1'b1, 1'b1);
    for (int f = 0; f < 8; f++) begin
      sof_step(1'b1);
      body((f % 4) < 2, 1'b1);
    end
    sof_step(1'b1);
    body(1'b0, 1'b0);

    // Request coincident with the strobe; a retrigger during FLASH_OFF must not extend it
    sof_step(1'b0, 1'b1);
    body(1'b1, 1'b1);
    for (int f = 1; f < 8; f++) begin
      sof_step(1'b1);
      body((f % 4) < 2, 1'b1, f == 2);
    end
    sof_step(1'b1);
    body(1'b0, 1'b0);
    sof_step(1'b0);
    body(1'b0, 1'b0);

    // Reset during FLASH_ON aborts the flash
    sof_step(1'b0, 1'b1);
    body(1'b1, 1'b1);
    async_reset_check("rst_flash");
    sof_step(1'b0);
    body(1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
